// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the register-file dump reader.
// Sized for the MIPS 32 x 32-bit register file.
package regfile_pkg;
    localparam int REG_W     = 32;
    localparam int REG_AW    = 5;
    localparam int REG_COUNT = 32;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } dump_state_t;
endpackage

// File: rtl/dump_out_stage.sv
// One-entry valid/ready output register for debug streamers.
// free means a new beat may be loaded at the coming edge.
module dump_out_stage #(
    parameter int W  = 32,
    parameter int AW = 5
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          load,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  data,
    input  logic          last,
    input  logic          DumpReady,
    output logic          free,
    output logic          DumpValid,
    output logic [W-1:0]  DumpData,
    output logic [AW-1:0] DumpAddr,
    output logic          DumpLast
);
    assign free = !DumpValid || DumpReady;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            DumpValid <= 1'b0;
            DumpData  <= '0;
            DumpAddr  <= '0;
            DumpLast  <= 1'b0;
        end else if (load) begin
            DumpValid <= 1'b1;
            DumpData  <= data;
            DumpAddr  <= addr;
            DumpLast  <= last;
        end else if (DumpReady) begin
            DumpValid <= 1'b0;
        end
    end
endmodule

// File: rtl/regfile_dump_reader.sv
// Walks a register range through an async read port and streams
// {addr, data} beats; flags the dump stale if a dumped reg is rewritten.
module regfile_dump_reader
    import regfile_pkg::*;
#(
    parameter int W  = REG_W,
    parameter int AW = REG_AW
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [AW-1:0] FirstReg,
    input  logic [AW-1:0] LastReg,
    output logic [AW-1:0] ReadRegister,
    input  logic [W-1:0]  ReadData,
    input  logic          SnoopRegWrite,
    input  logic [AW-1:0] SnoopWriteRegister,
    output logic [W-1:0]  DumpData,
    output logic [AW-1:0] DumpAddr,
    output logic          DumpLast,
    output logic          DumpValid,
    input  logic          DumpReady,
    output logic          Busy,
    output logic          Done,
    output logic          Stale
);
    localparam int N = 2 ** AW;

    dump_state_t   state, state_nx;
    logic [AW-1:0] ptr, ptr_nx;
    logic [AW-1:0] last_reg, last_nx;
    logic [N-1:0]  mask, mask_nx;
    logic          stale_nx;
    logic          done_nx;
    logic          load;
    logic          free;
    logic          snoop_hit;

    assign Busy         = (state != IDLE);
    assign ReadRegister = (state == READ) ? ptr : '0;

    // A write hits if its target is already dumped or is being captured now.
    assign snoop_hit = SnoopRegWrite
                    && (SnoopWriteRegister != '0)
                    && (mask[SnoopWriteRegister]
                        || (load && (ptr == SnoopWriteRegister)));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            ptr      <= '0;
            last_reg <= '0;
            mask     <= '0;
            Stale    <= 1'b0;
            Done     <= 1'b0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            last_reg <= last_nx;
            mask     <= mask_nx;
            Stale    <= stale_nx;
            Done     <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        last_nx  = last_reg;
        mask_nx  = mask;
        stale_nx = Stale;
        done_nx  = 1'b0;
        load     = 1'b0;
        unique case (state)
            IDLE: begin
                if (Start) begin
                    state_nx = READ;
                    ptr_nx   = FirstReg;
                    last_nx  = LastReg;
                    mask_nx  = '0;
                    stale_nx = 1'b0;
                end
            end
            READ: begin
                if (free) begin
                    load          = 1'b1;
                    mask_nx[ptr]  = 1'b1;
                    if (ptr == last_reg) begin
                        state_nx = DRAIN;
                    end else begin
                        ptr_nx = ptr + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (DumpValid && DumpReady) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (Busy && snoop_hit) begin
            stale_nx = 1'b1;
        end
    end

    dump_out_stage #(
        .W (W),
        .AW(AW)
    ) u_out (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (load),
        .addr     (ptr),
        .data     (ReadData),
        .last     (ptr == last_reg),
        .DumpReady(DumpReady),
        .free     (free),
        .DumpValid(DumpValid),
        .DumpData (DumpData),
        .DumpAddr (DumpAddr),
        .DumpLast (DumpLast)
    );
endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a range/queue model
// of expected beats, busy/done/stale behaviour and a register file.
module tb_regfile_dump_reader;
    localparam int W  = 32;
    localparam int AW = 5;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Start;
    logic [AW-1:0] FirstReg;
    logic [AW-1:0] LastReg;
    logic [AW-1:0] ReadRegister;
    logic [W-1:0]  ReadData;
    logic          SnoopRegWrite;
    logic [AW-1:0] SnoopWriteRegister;
    logic [W-1:0]  DumpData;
    logic [AW-1:0] DumpAddr;
    logic          DumpLast;
    logic          DumpValid;
    logic          DumpReady;
    logic          Busy;
    logic          Done;
    logic          Stale;

    always #5 Clk = ~Clk;

    regfile_dump_reader #(.W(W), .AW(AW)) dut (
        .Clk               (Clk),
        .Reset             (Reset),
        .Start             (Start),
        .FirstReg          (FirstReg),
        .LastReg           (LastReg),
        .ReadRegister      (ReadRegister),
        .ReadData          (ReadData),
        .SnoopRegWrite     (SnoopRegWrite),
        .SnoopWriteRegister(SnoopWriteRegister),
        .DumpData          (DumpData),
        .DumpAddr          (DumpAddr),
        .DumpLast          (DumpLast),
        .DumpValid         (DumpValid),
        .DumpReady         (DumpReady),
        .Busy              (Busy),
        .Done              (Done),
        .Stale             (Stale)
    );

    // Register file: preload port for setup, write port seen by the snoop.
    logic [W-1:0]  regs [32];
    logic          pl;
    logic [AW-1:0] pl_addr;
    logic [W-1:0]  pl_data;
    logic [W-1:0]  wd;

    always @(posedge Clk) begin
        if (pl) regs[pl_addr] <= pl_data;
        else if (SnoopRegWrite && SnoopWriteRegister != 0)
            regs[SnoopWriteRegister] <= wd;
    end

    assign ReadData = regs[ReadRegister];

    typedef struct {
        logic [AW-1:0] addr;
        logic          last;
    } beat_t;

    beat_t         q [$];
    bit            busy_m, stale_m, done_m, hold_v, chk_en;
    logic [AW-1:0] h_addr;
    logic [W-1:0]  h_data;
    logic          h_last;
    bit            acc [32];
    int            ss = -1;
    int            acc_cnt, done_cnt, nbeats;
    logic [AW-1:0] log_addr [64];
    logic [W-1:0]  log_data [64];
    logic          log_last [64];
    int            tests, fails;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h want 0x%0h @%0t", nm, act, want,
                     $time);
        end
    endtask

    task automatic flag(input string nm);
        tests++;
        fails++;
        $display("FAIL %s @%0t", nm, $time);
    endtask

    // Called once per cycle at the falling edge: check current outputs,
    // then predict the effect of the coming rising edge.
    task automatic model_step();
        bit    b0;
        beat_t e;
        int    n;
        b0 = busy_m;
        if (chk_en) begin
            check("busy", Busy, busy_m);
            check("stale", Stale, stale_m);
            check("done", Done, done_m);
            if (Done) done_cnt++;
            if (!busy_m) begin
                check("idle_valid", DumpValid, 0);
                check("idle_rdreg", ReadRegister, 0);
            end
            if (ss >= 0) begin
                ss++;
                if (ss == 1) check("lat_edge0", DumpValid, 0);
                else if (ss == 2) begin
                    check("lat_edge1", DumpValid, 1);
                    ss = -1;
                end
            end
            if (hold_v) begin
                check("hold_valid", DumpValid, 1);
                check("hold_addr", DumpAddr, h_addr);
                check("hold_data", DumpData, h_data);
                check("hold_last", DumpLast, h_last);
            end
        end
        done_m = 0;
        hold_v = 0;
        if (Reset) begin
            q.delete();
            busy_m  = 0;
            stale_m = 0;
            ss      = -1;
            return;
        end
        if (b0 && SnoopRegWrite && SnoopWriteRegister != 0
            && acc[SnoopWriteRegister])
            stale_m = 1;
        if (DumpValid && !DumpReady) begin
            hold_v = 1;
            h_addr = DumpAddr;
            h_data = DumpData;
            h_last = DumpLast;
        end
        if (DumpValid && DumpReady) begin
            if (q.size() == 0) begin
                flag("extra_beat");
            end else begin
                e = q.pop_front();
                check("beat_addr", DumpAddr, e.addr);
                check("beat_last", DumpLast, e.last);
                check("beat_data", DumpData, regs[DumpAddr]);
                if (nbeats < 64) begin
                    log_addr[nbeats] = DumpAddr;
                    log_data[nbeats] = DumpData;
                    log_last[nbeats] = DumpLast;
                end
                nbeats++;
                acc[DumpAddr] = 1;
                acc_cnt++;
                if (e.last) begin
                    busy_m = 0;
                    done_m = 1;
                end
            end
        end
        if (Start && !b0) begin
            n = ((int'(LastReg) - int'(FirstReg) + 32) % 32) + 1;
            q.delete();
            for (int i = 0; i < n; i++) begin
                e.addr = AW'((int'(FirstReg) + i) % 32);
                e.last = (i == n - 1);
                q.push_back(e);
            end
            for (int i = 0; i < 32; i++) acc[i] = 0;
            busy_m  = 1;
            stale_m = 0;
            ss      = 0;
            acc_cnt = 0;
            nbeats  = 0;
        end
    endtask

    task automatic tick();
        @(negedge Clk);
        model_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic preload();
        for (int r = 0; r < 32; r++) begin
            pl      = 1'b1;
            pl_addr = AW'(r);
            pl_data = 32'h100 + r;
            tick();
        end
        pl = 1'b0;
    endtask

    task automatic start_dump(input int f, input int l);
        FirstReg = AW'(f);
        LastReg  = AW'(l);
        Start    = 1'b1;
        tick();
        Start    = 1'b0;
    endtask

    task automatic snoop_write(input int a, input logic [W-1:0] d);
        SnoopRegWrite      = 1'b1;
        SnoopWriteRegister = AW'(a);
        wd                 = d;
        tick();
        SnoopRegWrite      = 1'b0;
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0,1,...
    task automatic run(input int mode, input int maxc);
        int dc0;
        dc0 = done_cnt;
        for (int c = 0; c < maxc && done_cnt == dc0; c++) begin
            if (mode == 0) DumpReady = 1'b1;
            else DumpReady = (c % 4 == 0) || (c % 4 == 3);
            tick();
        end
        if (done_cnt == dc0) flag("done_timeout");
        DumpReady = 1'b1;
    endtask

    task automatic wait_acc(input int k, input int maxc);
        for (int c = 0; c < maxc && acc_cnt < k; c++) tick();
        if (acc_cnt < k) flag("beat_timeout");
    endtask

    int dc;

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        FirstReg = '0;
        LastReg = '0;
        SnoopRegWrite = 1'b0;
        SnoopWriteRegister = '0;
        DumpReady = 1'b0;
        pl = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        wd = '0;
        tick();
        tick();
        Reset = 1'b0;
        chk_en = 1'b1;
        tick();
        check("rst_valid", DumpValid, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_stale", Stale, 0);
        check("rst_rdreg", ReadRegister, 0);

        preload();

        // Full dump at full throughput
        DumpReady = 1'b1;
        dc = done_cnt;
        start_dump(0, 31);
        run(0, 100);
        check("full_beats", nbeats, 32);
        check("full_addr31", log_addr[31], 31);
        check("full_data31", log_data[31], 32'h11F);
        check("full_data0", log_data[0], 32'h100);
        check("full_last30", log_last[30], 0);
        check("full_last31", log_last[31], 1);
        check("full_done1", done_cnt, dc + 1);
        check("full_busy_after", Busy, 0);

        // Backpressure
        start_dump(4, 7);
        run(1, 100);
        check("bp_beats", nbeats, 4);
        for (int i = 0; i < 4; i++) check("bp_addr", log_addr[i], 4 + i);

        // Wrap and single register
        start_dump(30, 1);
        run(0, 100);
        check("wrap_beats", nbeats, 4);
        check("wrap_addr2", log_addr[2], 0);
        check("wrap_last3", log_last[3], 1);
        check("wrap_last2", log_last[2], 0);
        start_dump(9, 9);
        run(0, 100);
        check("one_beats", nbeats, 1);
        check("one_addr", log_addr[0], 9);
        check("one_last", log_last[0], 1);

        // Stale: write an already-dumped register while stalled
        start_dump(0, 31);
        wait_acc(6, 50);
        DumpReady = 1'b0;
        snoop_write(3, 32'hDEAD);
        tick();
        check("stale_r3", Stale, 1);
        dc = done_cnt;
        run(0, 100);
        check("stale_hold_done", Stale, 1);
        check("stale_r3_done", done_cnt, dc + 1);
        preload();
        check("stale_clr_idle", Stale, 1);

        // Write to a register not yet dumped
        start_dump(0, 31);
        wait_acc(6, 50);
        DumpReady = 1'b0;
        snoop_write(20, 32'hDEAD);
        tick();
        check("fresh_r20", Stale, 0);
        run(0, 100);
        check("fresh_data20", log_data[20], 32'hDEAD);
        check("fresh_stale", Stale, 0);
        preload();

        // Write to r0 never marks stale
        start_dump(0, 31);
        wait_acc(6, 50);
        DumpReady = 1'b0;
        snoop_write(0, 32'hBEEF);
        tick();
        check("r0_stale", Stale, 0);
        run(0, 100);
        check("r0_data0", log_data[0], 32'h100);

        // Start during a dump is ignored
        DumpReady = 1'b1;
        dc = done_cnt;
        start_dump(0, 15);
        for (int c = 0; c < 6; c++) begin
            DumpReady = (c % 4 == 0) || (c % 4 == 3);
            tick();
        end
        start_dump(20, 25);
        run(1, 200);
        check("ign_beats", nbeats, 16);
        check("ign_addr15", log_addr[15], 15);
        for (int c = 0; c < 10; c++) tick();
        check("ign_done1", done_cnt, dc + 1);
        check("ign_idle", Busy, 0);

        // Reset mid-dump
        DumpReady = 1'b1;
        start_dump(0, 31);
        wait_acc(11, 50);
        snoop_write(2, 32'hBAD);
        tick();
        check("rst_mid_stale", Stale, 1);
        dc = done_cnt;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("rst_mid_valid", DumpValid, 0);
        check("rst_mid_busy", Busy, 0);
        check("rst_mid_stale0", Stale, 0);
        for (int c = 0; c < 5; c++) tick();
        check("rst_mid_nodone", done_cnt, dc);
        start_dump(5, 8);
        run(0, 100);
        check("rst_re_beats", nbeats, 4);
        check("rst_re_addr0", log_addr[0], 5);
        check("rst_re_data0", log_data[0], 32'h105);
        check("rst_re_last3", log_last[3], 1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
